sub_bytes_seq_engine: RTL and testbench



---
 rtl/aes_mod_pkg.sv | 47 ++++
 rtl/seeded_sbox_lane.sv | 13 +
 rtl/sub_bytes_seq_engine.sv | 92 +++++++++
 tb/tb_sub_bytes_seq_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mod_pkg.sv
// Shared types and helpers for the modified AES-256 datapath:
// forward S-box table, SubBytes FSM states and seed byte selection.
package aes_mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int LANES = 4;

    // Byte x lives at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    // Only the low five bits of the round select a seed byte
    function automatic logic [7:0] seed_byte(
        input logic [255:0] seed,
        input logic [31:0]  idx
    );
        logic [4:0] j;
        j = idx[4:0];
        return seed[8'd255 - {j, 3'b000} -: 8];
    endfunction

endpackage

// File: rtl/seeded_sbox_lane.sv
// One byte lane of the seeded forward S-box: y = SBOX(x ^ k1) ^ k2.
module seeded_sbox_lane
    import aes_mod_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] k1,
    input  logic [7:0] k2,
    output logic [7:0] y
);

    assign y = sbox(x ^ k1) ^ k2;

endmodule

// File: rtl/sub_bytes_seq_engine.sv
// Sequential seeded SubBytes, four bytes per cycle, valid/ready on both sides.
// SUBBYTES_TRACE_EN adds a simulation-only print at each output handshake.
module sub_bytes_seq_engine
    import aes_mod_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [255:0] sbox_seed,
    input  logic [31:0]  round_num,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);

    sub_state_t   state;
    sub_state_t   state_nxt;
    logic [127:0] st;
    logic [7:0]   k1;
    logic [7:0]   k2;
    logic [1:0]   cnt;
    logic [31:0]  word_in;
    logic [31:0]  word_out;

    // Lane group c covers bytes 4c..4c+3
    assign word_in = st[7'd127 - {cnt, 5'd0} -: 32];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        seeded_sbox_lane u_lane (
            .x  (word_in[31-8*l -: 8]),
            .k1 (k1),
            .k2 (k2),
            .y  (word_out[31-8*l -: 8])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid)       state_nxt = SUB;
            SUB:  if (cnt == 2'd3)    state_nxt = DONE;
            DONE: if (out_ready)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            k1    <= '0;
            k2    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                st  <= in;
                k1  <= seed_byte(sbox_seed, round_num);
                k2  <= seed_byte(sbox_seed, round_num + 32'd1);
                cnt <= '0;
            end else if (state == SUB) begin
                st[7'd127 - {cnt, 5'd0} -: 32] <= word_out;
                cnt <= cnt + 2'd1;
            end
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == SUB) || (state == DONE);
    assign out       = st;

`ifdef SUBBYTES_TRACE_EN
    logic [31:0] trace_round;

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_round <= '0;
        end else begin
            if (state == IDLE && in_valid)
                trace_round <= round_num;
            if (out_valid && out_ready)
                $display("In Encryption, Round Number: %d, Generated Output: %h",
                         trace_round, out);
        end
    end
`endif

endmodule

// File: tb/tb_sub_bytes_seq_engine.sv
// Directed and round-trip checks for the sequential seeded SubBytes engine.
module tb_sub_bytes_seq_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [255:0] seed_i = '0;
    logic [31:0]  round_i = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sub_bytes_seq_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .sbox_seed (seed_i),
        .round_num (round_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data),
        .busy      (busy)
    );

    localparam logic [2047:0] TB_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] inv_tab [256];

    typedef struct {
        logic [127:0] din;
        logic [255:0] seed;
        logic [31:0]  rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [7:0] fwd(input logic [7:0] x);
        logic [2047:0] t;
        t = TB_SBOX;
        return t[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] sbyte(input logic [255:0] s, input logic [4:0] j);
        return s[8'd255 - {j, 3'b000} -: 8];
    endfunction

    // Decryption-side inverse substitution: x = INV(y ^ k2) ^ k1
    function automatic logic [127:0] inv_sub(
        input logic [127:0] y,
        input logic [255:0] s,
        input logic [31:0]  r
    );
        logic [127:0] x;
        logic [7:0]   a;
        logic [7:0]   b;
        logic [31:0]  r1;
        r1 = r + 32'd1;
        a = sbyte(s, r[4:0]);
        b = sbyte(s, r1[4:0]);
        for (int i = 0; i < 16; i++)
            x[127-8*i -: 8] = inv_tab[y[127-8*i -: 8] ^ b] ^ a;
        return x;
    endfunction

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Offer one block, wait for the result, complete the handshake
    task automatic run_block(
        input  logic [127:0] din,
        input  logic [255:0] seed,
        input  logic [31:0]  rnd,
        input  logic         early_ready,
        output logic [127:0] dout,
        output int           lat
    );
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_data  = din;
        seed_i   = seed;
        round_i  = rnd;
        in_valid = 1'b1;
        out_ready = early_ready;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dout = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [127:0] res;
    logic [127:0] held;
    int           lat;
    logic [127:0] rin;
    logic [255:0] rseed;
    logic [31:0]  rrnd;
    int           n;

    initial begin
        for (int i = 0; i < 256; i++)
            inv_tab[fwd(8'(i))] = 8'(i);

        vecs[0] = '{128'h0, 256'h0, 32'd0, {16{8'h63}}};
        vecs[1] = '{128'h0, {8'h00, 8'h01, 240'h0}, 32'd1, {16{8'h7c}}};
        vecs[2] = '{128'h0, {8'h00, 8'h01, 240'h0}, 32'd33, {16{8'h7c}}};
        vecs[3] = '{{16{8'h53}}, {8'h00, 8'hff, 240'h0}, 32'd0, {16{8'h12}}};
        vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 256'h0, 32'd0,
                    128'h637c777bf26b6fc53001672bfed7ab76};

        // Reset
        @(negedge clk);
        chk("in_ready_in_reset", {127'h0, in_ready}, 128'h0);
        @(negedge clk);
        chk("out_valid_reset", {127'h0, out_valid}, 128'h0);
        chk("busy_reset", {127'h0, busy}, 128'h0);
        chk("out_reset", out_data, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", {127'h0, in_ready}, 128'h1);

        foreach (vecs[i]) begin
            run_block(vecs[i].din, vecs[i].seed, vecs[i].rnd, 1'b0, res, lat);
            chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd4);
            chk($sformatf("vec%0d_in_ready", i), {127'h0, in_ready}, 128'h1);
            chk($sformatf("vec%0d_valid_drop", i), {127'h0, out_valid}, 128'h0);
        end

        // Round 31: k1 = byte31, k2 wraps to byte0
        run_block(128'h0, {8'haa, 240'h0, 8'h01}, 32'd31, 1'b0, res, lat);
        chk("wrap31_out", res, {16{8'hd6}});

        // out_ready high long before DONE
        run_block({16{8'h53}}, 256'h0, 32'd0, 1'b1, res, lat);
        chk("early_ready_lat", 128'(lat), 128'd4);
        chk("early_ready_out", res, {16{8'hed}});

        // Backpressure with a second block pending
        in_data = 128'h0; seed_i = '0; round_i = '0;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = {16{8'h53}};
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_first_valid", {127'h0, out_valid}, 128'h1);
        held = out_data;
        chk("bp_first_out", held, {16{8'h63}});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", c),
                {out_data, out_valid, in_ready}, {held, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_in_ready_after", {127'h0, in_ready}, 128'h1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_lat", 128'(n), 128'd4);
        chk("bp_second_out", out_data, {16{8'hed}});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the second SUB cycle
        in_data = {16{8'h53}}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_state",
            {out_data, out_valid, busy}, {128'h0, 1'b0, 1'b0});
        @(negedge clk);
        chk("mid_rst_in_ready", {127'h0, in_ready}, 128'h1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_no_valid%0d", c), {127'h0, out_valid}, 128'h0);
        end
        run_block(vecs[4].din, vecs[4].seed, vecs[4].rnd, 1'b0, res, lat);
        chk("mid_rst_next_out", res, vecs[4].exp);

        // Reset and in_valid together
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wins", {126'h0, busy, out_valid}, 128'h0);

        // Round trip through the inverse substitution
        for (int v = 0; v < 100; v++) begin
            rin = {$urandom, $urandom, $urandom, $urandom};
            rseed = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
            rrnd = $urandom;
            run_block(rin, rseed, rrnd, 1'b0, res, lat);
            chk($sformatf("round_trip%0d", v), inv_sub(res, rseed, rrnd), rin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
